sweep_counter_ctrl: RTL and testbench



---
 rtl/sweep_counter_ctrl_pkg.sv | 22 ++
 rtl/sweep_counter_ctrl_if.sv | 29 ++
 rtl/sweep_counter_ctrl_core.sv | 29 ++
 rtl/sweep_counter_ctrl.sv | 156 +++++++++++++++
 tb/tb_sweep_counter_ctrl.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sweep_counter_ctrl_pkg.sv
// Shared types for the sweep counter controller: FSM state encoding,
// direction constants and the count-register operation select.
package sweep_counter_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      UP   = 2'b01,
      DOWN = 2'b10,
      DONE = 2'b11
   } state_e;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   typedef enum logic [1:0] {
      OP_HOLD = 2'b00,
      OP_LOAD = 2'b01,
      OP_INC  = 2'b10,
      OP_DEC  = 2'b11
   } cnt_op_e;

endpackage

// File: rtl/sweep_counter_ctrl_if.sv
// Control/status bundle between a sweep requester (master) and the
// sweep counter controller (slave).
interface sweep_counter_ctrl_if #(
   parameter int WIDTH    = 3,
   parameter int SWEEPS_W = 4
);
   logic                start;
   logic                stop;
   logic                pause;
   logic [WIDTH-1:0]    lo;
   logic [WIDTH-1:0]    hi;
   logic [SWEEPS_W-1:0] sweeps;
   logic [WIDTH-1:0]    count;
   logic                dir;
   logic                busy;
   logic                done;
   logic                err;
   logic [SWEEPS_W-1:0] sweep_cnt;

   modport master (
      output start, stop, pause, lo, hi, sweeps,
      input  count, dir, busy, done, err, sweep_cnt
   );

   modport slave (
      input  start, stop, pause, lo, hi, sweeps,
      output count, dir, busy, done, err, sweep_cnt
   );
endinterface

// File: rtl/sweep_counter_ctrl_core.sv
// WIDTH-bit count register with load / increment / decrement / hold select;
// the controller guarantees it is never asked to step past a bound.
module sweep_count_core
   import sweep_counter_ctrl_pkg::*;
#(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  cnt_op_e          op,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count
);

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
      end else begin
         unique case (op)
            OP_LOAD: count <= load_val;
            OP_INC:  count <= count + WIDTH'(1);
            OP_DEC:  count <= count - WIDTH'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sweep_counter_ctrl.sv
// Triangle-sweep sequencer: counts lo->hi->lo for a programmed number of
// round trips under a start/done handshake with pause and stop.
module sweep_counter_ctrl
   import sweep_counter_ctrl_pkg::*;
#(
   parameter int WIDTH    = 3,
   parameter int SWEEPS_W = 4
) (
   input  logic                clk,
   input  logic                rst,
   sweep_counter_ctrl_if.slave bus
);

   state_e              state;
   state_e              state_nx;
   logic [WIDTH-1:0]    lo_q;
   logic [WIDTH-1:0]    hi_q;
   logic [WIDTH-1:0]    count;
   logic [WIDTH-1:0]    load_val;
   logic [SWEEPS_W-1:0] sweeps_q;
   logic [SWEEPS_W-1:0] sweep_cnt_q;
   logic [SWEEPS_W-1:0] sweep_cnt_nx;
   logic [SWEEPS_W-1:0] sweep_cnt_inc;
   logic                dir_q;
   logic                dir_nx;
   logic                busy_q;
   logic                done_q;
   logic                err_q;
   cnt_op_e             op;

   logic accept;
   logic reject;
   logic stepping;
   logic at_hi;
   logic at_lo;
   logic flat;
   logic last_sweep;

   assign accept        = (state == IDLE) && bus.start && (bus.lo <= bus.hi);
   assign reject        = (state == IDLE) && bus.start && (bus.lo >  bus.hi);
   assign stepping      = !bus.stop && !bus.pause;
   assign at_hi         = (count == hi_q);
   assign at_lo         = (count == lo_q);
   assign flat          = (lo_q == hi_q);
   assign sweep_cnt_inc = sweep_cnt_q + SWEEPS_W'(1);
   // sweeps == 0 means free-running, so the wrapped increment never matches.
   assign last_sweep    = (sweeps_q != '0) && (sweep_cnt_inc == sweeps_q);

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         lo_q        <= '0;
         hi_q        <= '0;
         sweeps_q    <= '0;
         sweep_cnt_q <= '0;
         dir_q       <= DIR_DN;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state       <= state_nx;
         sweep_cnt_q <= sweep_cnt_nx;
         dir_q       <= dir_nx;
         busy_q      <= (state_nx == UP) || (state_nx == DOWN);
         done_q      <= (state_nx == DONE);
         err_q       <= reject;
         if (accept) begin
            lo_q     <= bus.lo;
            hi_q     <= bus.hi;
            sweeps_q <= bus.sweeps;
         end
      end
   end

   // Next-state logic; stop outranks pause, which outranks stepping.
   always_comb begin
      // NOTE: defaults first so no path leaves a signal unassigned (no latch).
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (accept) state_nx = UP;
         end
         UP: begin
            if (bus.stop)              state_nx = IDLE;
            else if (!bus.pause && at_hi) state_nx = DOWN;
         end
         DOWN: begin
            if (bus.stop)                 state_nx = IDLE;
            else if (!bus.pause && at_lo) state_nx = last_sweep ? DONE : UP;
         end
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Datapath control: count op, direction and sweep counter updates.
   always_comb begin
      op           = OP_HOLD;
      load_val     = bus.lo;
      dir_nx       = dir_q;
      sweep_cnt_nx = sweep_cnt_q;
      unique case (state)
         IDLE: begin
            if (accept) begin
               op           = OP_LOAD;
               dir_nx       = DIR_UP;
               sweep_cnt_nx = '0;
            end
         end
         UP: begin
            if (stepping) begin
               if (!at_hi) begin
                  op = OP_INC;
               end else begin
                  dir_nx = DIR_DN;
                  // Turning at hi steps to hi-1, except a zero-width range holds.
                  if (!flat) op = OP_DEC;
               end
            end
         end
         DOWN: begin
            if (stepping) begin
               if (!at_lo) begin
                  op = OP_DEC;
               end else begin
                  sweep_cnt_nx = sweep_cnt_inc;
                  if (!last_sweep) begin
                     dir_nx = DIR_UP;
                     if (!flat) op = OP_INC;
                  end
               end
            end
         end
         default: ;
      endcase
   end

   sweep_count_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk      (clk),
      .rst      (rst),
      .op       (op),
      .load_val (load_val),
      .count    (count)
   );

   assign bus.count     = count;
   assign bus.dir       = dir_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.sweep_cnt = sweep_cnt_q;

endmodule

// File: tb/tb_sweep_counter_ctrl.sv
// Self-checking bench for sweep_counter_ctrl: vector table, directed corner
// sequences and randomized traffic against a phase-arithmetic reference model.
module tb_sweep_counter_ctrl;

   localparam int WIDTH    = 3;
   localparam int SWEEPS_W = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   sweep_counter_ctrl_if #(.WIDTH(WIDTH), .SWEEPS_W(SWEEPS_W)) bus ();

   sweep_counter_ctrl #(
      .WIDTH    (WIDTH),
      .SWEEPS_W (SWEEPS_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   // ---------------- reference model ----------------
   // A run is described by k = number of stepping cycles since accept.
   // Non-flat range d=hi-lo: count follows a triangle of period 2d starting at lo,
   // the first round trip completes after 2d+1 cycles, later ones every 2d.
   // Flat range: alternates UP/DOWN at lo, one round trip per 2 cycles.
   typedef enum {M_IDLE, M_RUN, M_DONE} mode_e;
   mode_e m_mode = M_IDLE;
   int m_k, m_lo, m_hi, m_sw;
   int m_count = 0, m_dir = 0, m_busy = 0, m_done = 0, m_err = 0, m_sc = 0;

   function automatic int m_period();
      return (m_hi == m_lo) ? 2 : 2 * (m_hi - m_lo);
   endfunction

   function automatic int m_offset();
      return (m_hi == m_lo) ? 0 : 1;
   endfunction

   function automatic void m_from_k();
      int d, p, o, ph;
      d  = m_hi - m_lo;
      p  = m_period();
      o  = m_offset();
      ph = m_k % p;
      if (d == 0) begin
         m_count = m_lo;
         m_dir   = (ph == 0) ? 1 : 0;
      end else begin
         m_count = m_lo + ((ph <= d) ? ph : p - ph);
         m_dir   = ((m_k == 0) || (ph >= 1 && ph <= d)) ? 1 : 0;
      end
      m_sc = ((m_k >= o) ? (m_k - o) / p : 0) % (1 << SWEEPS_W);
   endfunction

   function automatic void m_update();
      m_done = 0;
      m_err  = 0;
      if (!rst) begin
         m_mode = M_IDLE; m_count = 0; m_dir = 0; m_sc = 0; m_busy = 0;
      end else begin
         case (m_mode)
            M_IDLE: begin
               if (bus.start) begin
                  if (int'(bus.lo) > int'(bus.hi)) begin
                     m_err = 1;
                  end else begin
                     m_lo = int'(bus.lo); m_hi = int'(bus.hi); m_sw = int'(bus.sweeps);
                     m_k = 0; m_mode = M_RUN; m_busy = 1;
                     m_from_k();
                  end
               end
            end
            M_RUN: begin
               if (bus.stop) begin
                  m_mode = M_IDLE; m_busy = 0;
               end else if (!bus.pause) begin
                  m_k++;
                  if (m_sw != 0 && m_k == m_period() * m_sw + m_offset()) begin
                     m_mode = M_DONE; m_done = 1; m_busy = 0;
                     m_count = m_lo; m_dir = 0; m_sc = m_sw;
                  end else begin
                     m_from_k();
                  end
               end
            end
            default: m_mode = M_IDLE;
         endcase
      end
   endfunction

   // ---------------- helpers ----------------
   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic s, input logic st, input logic p,
                        input int l, input int h, input int sw);
      rst        = r;
      bus.start  = s;
      bus.stop   = st;
      bus.pause  = p;
      bus.lo     = WIDTH'(l);
      bus.hi     = WIDTH'(h);
      bus.sweeps = SWEEPS_W'(sw);
   endtask

   task automatic tick();
      @(posedge clk);
      m_update();
      #1;
   endtask

   task automatic check_model(input string tag);
      check({tag, ".count"},     int'(bus.count),     m_count);
      check({tag, ".dir"},       int'(bus.dir),       m_dir);
      check({tag, ".busy"},      int'(bus.busy),      m_busy);
      check({tag, ".done"},      int'(bus.done),      m_done);
      check({tag, ".err"},       int'(bus.err),       m_err);
      check({tag, ".sweep_cnt"}, int'(bus.sweep_cnt), m_sc);
   endtask

   task automatic tick_chk(input string tag);
      tick();
      check_model(tag);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic r, s, st, p;
      int   lo, hi, sw;
      int   e_count, e_dir, e_busy, e_done, e_err, e_sc;
   } vec_t;

   localparam int NVEC = 13;
   vec_t vecs [NVEC];

   initial begin
      automatic int done_seen;

      // lo=2 hi=4 sweeps=2; bounds/sweeps changed mid-run, start retried while busy and in DONE
      vecs[0]  = '{1, 1, 0, 0, 2, 4, 2, 2, 1, 1, 0, 0, 0};
      vecs[1]  = '{1, 1, 0, 0, 0, 7, 5, 3, 1, 1, 0, 0, 0};
      vecs[2]  = '{1, 0, 0, 0, 0, 7, 5, 4, 1, 1, 0, 0, 0};
      vecs[3]  = '{1, 0, 0, 0, 0, 7, 5, 3, 0, 1, 0, 0, 0};
      vecs[4]  = '{1, 0, 0, 0, 0, 7, 5, 2, 0, 1, 0, 0, 0};
      vecs[5]  = '{1, 0, 0, 0, 0, 7, 5, 3, 1, 1, 0, 0, 1};
      vecs[6]  = '{1, 0, 0, 0, 0, 7, 5, 4, 1, 1, 0, 0, 1};
      vecs[7]  = '{1, 0, 0, 0, 0, 7, 5, 3, 0, 1, 0, 0, 1};
      vecs[8]  = '{1, 0, 0, 0, 0, 7, 5, 2, 0, 1, 0, 0, 1};
      vecs[9]  = '{1, 0, 0, 0, 0, 7, 5, 2, 0, 0, 1, 0, 2};
      vecs[10] = '{1, 1, 0, 1, 1, 3, 1, 2, 0, 0, 0, 0, 2};
      vecs[11] = '{1, 1, 0, 0, 6, 1, 1, 2, 0, 0, 0, 1, 2};
      vecs[12] = '{1, 0, 0, 0, 6, 1, 1, 2, 0, 0, 0, 0, 2};

      // reset state
      drive(0, 0, 0, 0, 0, 0, 0);
      tick(); tick();
      check("rst.count", int'(bus.count), 0);
      check("rst.dir",   int'(bus.dir),   0);
      check("rst.busy",  int'(bus.busy),  0);
      check("rst.done",  int'(bus.done),  0);
      check("rst.err",   int'(bus.err),   0);
      check("rst.sc",    int'(bus.sweep_cnt), 0);

      for (int i = 0; i < NVEC; i++) begin
         drive(vecs[i].r, vecs[i].s, vecs[i].st, vecs[i].p, vecs[i].lo, vecs[i].hi, vecs[i].sw);
         tick();
         check($sformatf("vec%0d.count", i), int'(bus.count),     vecs[i].e_count);
         check($sformatf("vec%0d.dir", i),   int'(bus.dir),       vecs[i].e_dir);
         check($sformatf("vec%0d.busy", i),  int'(bus.busy),      vecs[i].e_busy);
         check($sformatf("vec%0d.done", i),  int'(bus.done),      vecs[i].e_done);
         check($sformatf("vec%0d.err", i),   int'(bus.err),       vecs[i].e_err);
         check($sformatf("vec%0d.sc", i),    int'(bus.sweep_cnt), vecs[i].e_sc);
      end

      // reset mid-run at count=3 going up
      drive(1, 1, 0, 0, 0, 7, 0);
      tick_chk("mid");
      drive(1, 0, 0, 0, 0, 7, 0);
      for (int i = 0; i < 10 && bus.count != 3; i++) tick_chk("mid");
      check("mid.reach3", int'(bus.count), 3);
      check("mid.busy",   int'(bus.busy),  1);
      drive(0, 0, 0, 0, 0, 7, 0);
      tick();
      check("mid.rst_count", int'(bus.count), 0);
      check("mid.rst_busy",  int'(bus.busy),  0);
      check("mid.rst_sc",    int'(bus.sweep_cnt), 0);
      check_model("mid.rst");

      // zero-width range: count pinned at 5 for three round trips
      drive(1, 1, 0, 0, 5, 5, 3);
      tick_chk("flat");
      drive(1, 0, 0, 0, 0, 7, 0);
      done_seen = 0;
      for (int i = 0; i < 20 && done_seen == 0; i++) begin
         tick_chk("flat");
         check("flat.count", int'(bus.count), 5);
         if (bus.done) begin
            done_seen = 1;
            check("flat.sc_at_done", int'(bus.sweep_cnt), 3);
         end
      end
      check("flat.done_seen", done_seen, 1);
      tick_chk("flat.after");
      check("flat.done_pulse", int'(bus.done), 0);

      // free-running 0..7: pause at 7, descend, stop at 4
      drive(1, 1, 0, 0, 0, 7, 0);
      tick_chk("pz");
      drive(1, 0, 0, 0, 0, 7, 0);
      for (int i = 0; i < 20 && bus.count != 7; i++) tick_chk("pz");
      check("pz.reach7", int'(bus.count), 7);
      drive(1, 0, 0, 1, 0, 7, 0);
      repeat (3) begin
         tick_chk("pz.hold");
         check("pz.hold_count", int'(bus.count), 7);
         check("pz.hold_dir",   int'(bus.dir),   1);
      end
      drive(1, 0, 0, 0, 0, 7, 0);
      tick_chk("pz.resume");
      check("pz.resume_count", int'(bus.count), 6);
      check("pz.resume_dir",   int'(bus.dir),   0);
      for (int i = 0; i < 10 && bus.count != 4; i++) tick_chk("pz.down");
      check("pz.reach4", int'(bus.count), 4);
      drive(1, 0, 1, 0, 0, 7, 0);
      tick_chk("pz.stop");
      check("pz.stop_busy",  int'(bus.busy),  0);
      check("pz.stop_count", int'(bus.count), 4);
      drive(1, 0, 0, 0, 0, 7, 0);
      repeat (3) begin
         tick_chk("pz.idle");
         check("pz.no_done", int'(bus.done), 0);
      end

      // stop and pause together while counting up: stop wins
      drive(1, 1, 0, 0, 1, 6, 0);
      tick_chk("sp");
      drive(1, 0, 0, 0, 1, 6, 0);
      tick_chk("sp"); tick_chk("sp");
      drive(1, 0, 1, 1, 1, 6, 0);
      tick_chk("sp.both");
      check("sp.busy",  int'(bus.busy),  0);
      check("sp.count", int'(bus.count), 3);
      drive(1, 0, 0, 0, 1, 6, 0);
      tick_chk("sp.idle");

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(0, 63) != 0),
               ($urandom_range(0, 7)  == 0),
               ($urandom_range(0, 31) == 0),
               ($urandom_range(0, 3)  == 0),
               int'($urandom_range(0, 7)),
               int'($urandom_range(0, 7)),
               int'($urandom_range(0, 3)));
         tick_chk("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
